// File: rtl/operand_fetch.sv
// operand_fetch: LC3 register-read stage between decode and execute.
// Reads both source operands (with same-cycle writeback forwarding),
// tracks in-flight destination writes in a per-register scoreboard,
// stalls decode on read-after-write hazards or scoreboard saturation,
// and hands operands on through a one-entry valid/ready output register.
// Optional build macro: STALL_CNT_EN adds a saturating 16-bit stall_count
// output counting cycles lost to hazards/saturation.
module operand_fetch #(
  parameter int CNT_W = 2,
  parameter int NREG  = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_sr1,
  input  logic [2:0]  in_sr2,
  input  logic [2:0]  in_dr,
  input  logic        in_use_sr1,
  input  logic        in_use_sr2,
  input  logic        in_wr_dr,
  output logic [2:0]  rf_sr1,
  output logic [2:0]  rf_sr2,
  input  logic [15:0] rf_d1,
  input  logic [15:0] rf_d2,
  input  logic        wb_en,
  input  logic [2:0]  wb_dr,
  input  logic [15:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_vsr1,
  output logic [15:0] out_vsr2,
  output logic [2:0]  out_dr,
  output logic        out_wr_dr
`ifdef STALL_CNT_EN
  ,
  output logic [15:0] stall_count
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {S_EMPTY, S_FULL} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt [NREG];
  logic [15:0]        r_vsr1;
  logic [15:0]        r_vsr2;
  logic [2:0]         r_dr;
  logic               r_wr_dr;

  logic               w_wb_hit1;
  logic               w_wb_hit2;
  logic               w_wb_hitd;
  logic [CNT_W-1:0]   w_cnt1;
  logic [CNT_W-1:0]   w_cnt2;
  logic [CNT_W-1:0]   w_cntd;
  logic               w_hazard1;
  logic               w_hazard2;
  logic               w_sat;
  logic               w_out_free;
  logic               w_accept;
  logic [15:0]        w_fwd1;
  logic [15:0]        w_fwd2;
  logic [NREG-1:0]    w_inc;
  logic [NREG-1:0]    w_dec;

  // Register-file read addresses follow decode directly.
  always_comb begin
    rf_sr1 = in_sr1;
    rf_sr2 = in_sr2;
  end

  // Forwarding, hazard and saturation detection; handshake towards decode.
  always_comb begin
    w_wb_hit1  = wb_en && (wb_dr == in_sr1);
    w_wb_hit2  = wb_en && (wb_dr == in_sr2);
    w_wb_hitd  = wb_en && (wb_dr == in_dr);
    w_cnt1     = r_cnt[in_sr1];
    w_cnt2     = r_cnt[in_sr2];
    w_cntd     = r_cnt[in_dr];
    w_fwd1     = w_wb_hit1 ? wb_data : rf_d1;
    w_fwd2     = w_wb_hit2 ? wb_data : rf_d2;
    // The last outstanding write landing this cycle is forwarded, not stalled.
    w_hazard1  = in_use_sr1 && (w_cnt1 != '0) && !(w_wb_hit1 && (w_cnt1 == CNT_ONE));
    w_hazard2  = in_use_sr2 && (w_cnt2 != '0) && !(w_wb_hit2 && (w_cnt2 == CNT_ONE));
    w_sat      = in_wr_dr && (w_cntd == CNT_MAX) && !w_wb_hitd;
    w_out_free = (r_state == S_EMPTY) || out_ready;
    in_ready   = reset && w_out_free && !w_hazard1 && !w_hazard2 && !w_sat;
    w_accept   = in_valid && in_ready;
  end

  // Per-register increment/decrement requests for the scoreboard.
  always_comb begin
    w_inc = '0;
    w_dec = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      w_inc[i] = w_accept && in_wr_dr && (32'(in_dr) == i);
      w_dec[i] = wb_en && (32'(wb_dr) == i) && (r_cnt[i] != '0);
    end
  end

  // Scoreboard counters; simultaneous inc and dec cancel out.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREG; i++) r_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (w_inc[i] && !w_dec[i])
          r_cnt[i] <= r_cnt[i] + CNT_ONE;
        else if (w_dec[i] && !w_inc[i])
          r_cnt[i] <= r_cnt[i] - CNT_ONE;
      end
    end
  end

  // Output FSM state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Output FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: if (w_accept) w_state_nxt = S_FULL;
      S_FULL:  if (out_ready && !w_accept) w_state_nxt = S_EMPTY;
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  // Output FSM outputs.
  always_comb begin
    out_valid = (r_state == S_FULL);
    out_vsr1  = r_vsr1;
    out_vsr2  = r_vsr2;
    out_dr    = r_dr;
    out_wr_dr = r_wr_dr;
  end

  // Operand payload register: loads on accept, otherwise holds.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_vsr1  <= '0;
      r_vsr2  <= '0;
      r_dr    <= '0;
      r_wr_dr <= 1'b0;
    end else if (w_accept) begin
      r_vsr1  <= w_fwd1;
      r_vsr2  <= w_fwd2;
      r_dr    <= in_dr;
      r_wr_dr <= in_wr_dr;
    end
  end

`ifdef STALL_CNT_EN
  logic [15:0] r_stall_cnt;
  logic        w_stall_evt;

  // A lost cycle counts only when decode was actually blocked by a hazard.
  always_comb begin
    w_stall_evt = in_valid && !in_ready && (w_hazard1 || w_hazard2 || w_sat);
    stall_count = r_stall_cnt;
  end

  // Saturating stall counter.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      r_stall_cnt <= '0;
    else if (w_stall_evt && (r_stall_cnt != '1))
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: reset state, a directed vector table,
// hand-written multi-cycle sequences (back-pressure, saturation, async reset)
// and a randomized phase, all checked against an integer-level reference model.
module tb_operand_fetch;

  localparam int MAXC = 3;  // 2^CNT_W - 1 for CNT_W = 2

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [2:0]  in_sr1, in_sr2, in_dr;
  logic        in_use_sr1, in_use_sr2, in_wr_dr;
  logic [2:0]  rf_sr1, rf_sr2;
  logic [15:0] rf_d1, rf_d2;
  logic        wb_en;
  logic [2:0]  wb_dr;
  logic [15:0] wb_data;
  logic        out_valid, out_ready;
  logic [15:0] out_vsr1, out_vsr2;
  logic [2:0]  out_dr;
  logic        out_wr_dr;
`ifdef STALL_CNT_EN
  logic [15:0] stall_count;
`endif

  operand_fetch #(.CNT_W(2), .NREG(8)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sr1(in_sr1), .in_sr2(in_sr2), .in_dr(in_dr),
    .in_use_sr1(in_use_sr1), .in_use_sr2(in_use_sr2), .in_wr_dr(in_wr_dr),
    .rf_sr1(rf_sr1), .rf_sr2(rf_sr2), .rf_d1(rf_d1), .rf_d2(rf_d2),
    .wb_en(wb_en), .wb_dr(wb_dr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_vsr1(out_vsr1), .out_vsr2(out_vsr2),
    .out_dr(out_dr), .out_wr_dr(out_wr_dr)
`ifdef STALL_CNT_EN
    , .stall_count(stall_count)
`endif
  );

  always #5 clock = ~clock;

  // Bench-side register file with asynchronous read.
  logic [15:0] rf_mem [8];
  assign rf_d1 = rf_mem[rf_sr1];
  assign rf_d2 = rf_mem[rf_sr2];

  int errors = 0;
  int checks = 0;

  // Reference model state
  int          mcnt [8];
  bit          m_ov;
  logic [15:0] m_v1, m_v2;
  logic [2:0]  m_dr;
  bit          m_wr;
  int          m_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_hazard(input logic [2:0] s, input bit use_s);
    return use_s && (mcnt[s] != 0) && !(wb_en && (wb_dr == s) && (mcnt[s] == 1));
  endfunction

  function automatic bit m_sat();
    return in_wr_dr && (mcnt[in_dr] == MAXC) && !(wb_en && (wb_dr == in_dr));
  endfunction

  function automatic bit m_ready();
    return (reset === 1'b1) && (!m_ov || out_ready) &&
           !m_hazard(in_sr1, in_use_sr1) && !m_hazard(in_sr2, in_use_sr2) && !m_sat();
  endfunction

  function automatic logic [15:0] m_fwd(input logic [2:0] s);
    return (wb_en && (wb_dr == s)) ? wb_data : rf_mem[s];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mcnt[i] = 0;
    m_ov = 0; m_v1 = '0; m_v2 = '0; m_dr = '0; m_wr = 0; m_stall = 0;
  endtask

  task automatic drive(input bit v, input logic [2:0] s1, input logic [2:0] s2,
                       input logic [2:0] d, input bit u1, input bit u2, input bit w,
                       input bit we, input logic [2:0] wd, input logic [15:0] wdat,
                       input bit ordy);
    in_valid = v; in_sr1 = s1; in_sr2 = s2; in_dr = d;
    in_use_sr1 = u1; in_use_sr2 = u2; in_wr_dr = w;
    wb_en = we; wb_dr = wd; wb_data = wdat; out_ready = ordy;
  endtask

  // One clock cycle; entered and left at a falling edge. rdy = sampled in_ready.
  task automatic cycle(output bit rdy);
    bit exp_rdy, acc, stall_evt;
    logic [15:0] f1, f2;
    #1;
    exp_rdy = m_ready();
    rdy = in_ready;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    chk("rf_sr1", 32'(rf_sr1), 32'(in_sr1));
    chk("rf_sr2", 32'(rf_sr2), 32'(in_sr2));
    acc = in_valid && exp_rdy;
    f1 = m_fwd(in_sr1);
    f2 = m_fwd(in_sr2);
    stall_evt = in_valid && !exp_rdy &&
                (m_hazard(in_sr1, in_use_sr1) || m_hazard(in_sr2, in_use_sr2) || m_sat());
    @(posedge clock);
    if (acc) begin
      m_ov = 1; m_v1 = f1; m_v2 = f2; m_dr = in_dr; m_wr = in_wr_dr;
    end else if (out_ready) begin
      m_ov = 0;
    end
    if (wb_en && mcnt[wb_dr] > 0) mcnt[wb_dr]--;
    if (acc && in_wr_dr) mcnt[in_dr]++;
    if (stall_evt && m_stall < 65535) m_stall++;
    if (wb_en) rf_mem[wb_dr] <= wb_data;
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("out_vsr1", 32'(out_vsr1), 32'(m_v1));
    chk("out_vsr2", 32'(out_vsr2), 32'(m_v2));
    chk("out_dr", 32'(out_dr), 32'(m_dr));
    chk("out_wr_dr", 32'(out_wr_dr), 32'(m_wr));
`ifdef STALL_CNT_EN
    chk("stall_count", 32'(stall_count), 32'(m_stall));
`endif
    @(negedge clock);
  endtask

  task automatic step(input bit v, input logic [2:0] s1, input logic [2:0] s2,
                      input logic [2:0] d, input bit u1, input bit u2, input bit w,
                      input bit we, input logic [2:0] wd, input logic [15:0] wdat,
                      input bit ordy, output bit rdy);
    drive(v, s1, s2, d, u1, u2, w, we, wd, wdat, ordy);
    cycle(rdy);
  endtask

  typedef struct {
    bit v; logic [2:0] s1, s2, d; bit u1, u2, w, we; logic [2:0] wd;
    logic [15:0] wdat; bit ordy;
    bit e_rdy; bit e_ov; logic [15:0] e_v1, e_v2;
  } vec_t;

  vec_t tbl [7];

  initial begin
    bit rdy;
    for (int i = 0; i < 8; i++) rf_mem[i] = 16'(16'h1111 * i);
    rf_mem[1] = 16'h1234; rf_mem[2] = 16'h00FF; rf_mem[7] = 16'h8000;
    model_reset();

    //            v s1 s2 d u1 u2 w we wd wdat      ordy rdy ov v1        v2
    tbl[0] = '{1, 1, 2, 0, 1, 1, 0, 0, 0, 16'h0000, 1,   1,  1, 16'h1234, 16'h00FF}; // plain read
    tbl[1] = '{1, 0, 0, 3, 0, 0, 1, 0, 0, 16'h0000, 1,   1,  1, 16'h0000, 16'h0000}; // I0 writes r3
    tbl[2] = '{1, 3, 0, 0, 1, 0, 0, 0, 0, 16'h0000, 1,   0,  0, 16'h0000, 16'h0000}; // I1 RAW stall
    tbl[3] = '{1, 3, 0, 0, 1, 0, 0, 1, 3, 16'hBEEF, 1,   1,  1, 16'hBEEF, 16'h0000}; // forward
    tbl[4] = '{1, 0, 0, 3, 0, 0, 1, 0, 0, 16'h0000, 1,   1,  1, 16'h0000, 16'h0000}; // pend r3
    tbl[5] = '{1, 7, 4, 0, 1, 1, 0, 0, 0, 16'h0000, 1,   1,  1, 16'h8000, 16'h4444}; // high addr
    tbl[6] = '{0, 0, 0, 0, 0, 0, 0, 1, 3, 16'h3333, 1,   1,  0, 16'h8000, 16'h4444}; // drain r3

    // Reset state, with decode pushing to prove in_ready is gated by reset
    reset = 1'b0;
    drive(1, 1, 2, 0, 1, 1, 0, 0, 0, 16'h0, 1);
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_vsr1", 32'(out_vsr1), 32'd0);
    chk("rst_out_vsr2", 32'(out_vsr2), 32'd0);
    chk("rst_out_dr", 32'(out_dr), 32'd0);
    chk("rst_out_wr_dr", 32'(out_wr_dr), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
`ifdef STALL_CNT_EN
    chk("rst_stall_count", 32'(stall_count), 32'd0);
`endif
    @(negedge clock);
    reset = 1'b1;

    // Directed vector table
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].v, tbl[i].s1, tbl[i].s2, tbl[i].d, tbl[i].u1, tbl[i].u2, tbl[i].w,
           tbl[i].we, tbl[i].wd, tbl[i].wdat, tbl[i].ordy, rdy);
      chk($sformatf("tbl%0d_rdy", i), 32'(rdy), 32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d_ov", i), 32'(out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_v1", i), 32'(out_vsr1), 32'(tbl[i].e_v1));
      chk($sformatf("tbl%0d_v2", i), 32'(out_vsr2), 32'(tbl[i].e_v2));
    end

    // Back-pressure: hold three cycles, then back-to-back accept
    step(1, 1, 2, 0, 1, 1, 0, 0, 0, 16'h0, 1, rdy);
    for (int k = 0; k < 3; k++) begin
      step(1, 6, 6, 0, 1, 1, 0, 0, 0, 16'h0, 0, rdy);
      chk("bp_rdy", 32'(rdy), 32'd0);
      chk("bp_ov", 32'(out_valid), 32'd1);
      chk("bp_v1", 32'(out_vsr1), 32'h1234);
      chk("bp_v2", 32'(out_vsr2), 32'h00FF);
    end
    step(1, 6, 5, 0, 1, 1, 0, 0, 0, 16'h0, 1, rdy);
    chk("b2b_rdy", 32'(rdy), 32'd1);
    chk("b2b_ov", 32'(out_valid), 32'd1);
    chk("b2b_v1", 32'(out_vsr1), 32'h6666);
    chk("b2b_v2", 32'(out_vsr2), 32'h5555);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0, 1, rdy);

    // Saturation on r5
    for (int k = 0; k < 3; k++) step(1, 0, 0, 5, 0, 0, 1, 0, 0, 16'h0, 1, rdy);
    step(1, 0, 0, 5, 0, 0, 1, 0, 0, 16'h0, 1, rdy);
    chk("sat_rdy", 32'(rdy), 32'd0);
    step(1, 0, 0, 5, 0, 0, 1, 1, 5, 16'hA5A5, 1, rdy);
    chk("sat_wb_rdy", 32'(rdy), 32'd1);
    step(1, 0, 0, 5, 0, 0, 1, 0, 0, 16'h0, 1, rdy);
    chk("sat_still3_rdy", 32'(rdy), 32'd0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0, 0, 1, 5, 16'h5A5A, 1, rdy);
`ifdef STALL_CNT_EN
    chk("stall_count_dir", 32'(stall_count), 32'd3);
`endif

    // Asynchronous reset while FULL with a pending write to r2
    step(1, 0, 0, 2, 0, 0, 1, 0, 0, 16'h0, 1, rdy);
    drive(1, 2, 0, 0, 1, 0, 0, 0, 0, 16'h0, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_ov", 32'(out_valid), 32'd0);
    chk("arst_v1", 32'(out_vsr1), 32'd0);
    chk("arst_rdy", 32'(in_ready), 32'd0);
    model_reset();
`ifdef STALL_CNT_EN
    chk("arst_stall_count", 32'(stall_count), 32'd0);
`endif
    @(negedge clock);
    reset = 1'b1;
    step(1, 2, 0, 0, 1, 0, 0, 0, 0, 16'h0, 1, rdy);
    chk("post_arst_rdy", 32'(rdy), 32'd1);

    // Randomized phase against the reference model
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom),
           $urandom_range(0, 9) < 4, 3'($urandom_range(0, 7)), 16'($urandom),
           $urandom_range(0, 9) < 7, rdy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
